// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the serial program loader
package loader_pkg;
    localparam int CNT_W = 9;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_CSUM, S_RUN, S_ERROR} loader_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchronizer, glitch rejection and break handling
module uart_rx import loader_pkg::*; #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    logic [1:0] sync_q;
    rx_state_t st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic valid_q, valid_d, ferr_q, ferr_d;
    logic rx_s;
    assign rx_s = sync_q[1];
    assign data = shift_q;
    assign byte_valid = valid_q;
    assign frame_err = ferr_q;
    // synchronizer and receiver state; sync resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
    // bit timing: start checked at half bit, data and stop one full bit apart; break waits for line high
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) st_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d = '0;
                bit_d = '0;
                st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                valid_d = rx_s;
                ferr_d  = !rx_s;
                st_d    = rx_s ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (rx_s) st_d = RX_IDLE;
            end
            default: st_d = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART frame parser that writes program memory and gates the CPU on a valid checksum
module prog_loader import loader_pkg::*; #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_run,
    output logic        busy,
    output logic        err
);
    logic [7:0] data;
    logic byte_valid, frame_err;
    loader_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [7:0] sum_q, sum_d, hi_q, hi_d, sum_nx, wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic wr_en_q, wr_en_d, run_q, run_d, busy_q, busy_d, err_q, err_d;
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );
    assign sum_nx  = sum_q + data;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cpu_run = run_q;
    assign busy    = busy_q;
    assign err     = err_q;
    // framing state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            sum_q     <= '0;
            hi_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            sum_q     <= sum_d;
            hi_q      <= hi_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end
    // frame parsing; a sync byte only restarts outside a frame, inside it is ordinary data
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        sum_d     = sum_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        run_d     = run_q;
        busy_d    = busy_q;
        err_d     = err_q;
        if (frame_err && state_q inside {S_COUNT, S_HI, S_LO, S_CSUM}) begin
            state_d = S_ERROR;
            run_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else if (byte_valid) begin
            case (state_q)
                S_COUNT: begin
                    cnt_d   = (data == 8'h00) ? 9'd256 : {1'b0, data};
                    sum_d   = sum_nx;
                    state_d = S_HI;
                end
                S_HI: begin
                    hi_d    = data;
                    sum_d   = sum_nx;
                    state_d = S_LO;
                end
                S_LO: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[7:0];
                    wr_data_d = {hi_q, data};
                    sum_d     = sum_nx;
                    addr_d    = addr_q + 9'd1;
                    state_d   = (addr_q + 9'd1 == cnt_q) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    busy_d  = 1'b0;
                    run_d   = (sum_nx == 8'h00);
                    err_d   = (sum_nx != 8'h00);
                    state_d = (sum_nx == 8'h00) ? S_RUN : S_ERROR;
                end
                default: if (data == SYNC_BYTE) begin
                    state_d = S_COUNT;
                    run_d   = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    sum_d   = '0;
                end
            endcase
        end
    end
endmodule
